// File: rtl/prog_mem_arbiter.sv
// Shares one single-port program memory between instruction fetch and the loader/debug port.
// Fetch has priority; a starvation counter forces a loader win after STARVE_MAX denials.
module prog_mem_arbiter #(
  parameter int RAM_WIDTH  = 22,
  parameter int ADDR_SIZE  = 11,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_req,
  input  logic [ADDR_SIZE-1:0] f_addr,
  output logic                 f_gnt,
  output logic [RAM_WIDTH-1:0] f_rdata,
  output logic                 f_rvalid,
  input  logic                 l_req,
  input  logic                 l_we,
  input  logic [ADDR_SIZE-1:0] l_addr,
  input  logic [RAM_WIDTH-1:0] l_wdata,
  output logic                 l_gnt,
  output logic [RAM_WIDTH-1:0] l_rdata,
  output logic                 l_rvalid,
  output logic                 mem_wr_enb,
  output logic                 mem_rd_enb,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0] mem_data_in,
  input  logic [RAM_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LOADER = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  owner_e     r_rd_owner;
  owner_e     w_rd_owner_nxt;
  logic       w_starved;
  logic       w_f_gnt;
  logic       w_l_gnt;

  assign w_starved = (r_starve_cnt >= STARVE_LIM);

  // Grant decision; reset forces both grants low so nothing reaches the memory.
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (!rst_n) begin
      w_f_gnt = 1'b0;
      w_l_gnt = 1'b0;
    end else begin
      case ({f_req, l_req})
        2'b10:   w_f_gnt = 1'b1;
        2'b01:   w_l_gnt = 1'b1;
        2'b11: begin
          if (w_starved) begin
            w_l_gnt = 1'b1;
          end else begin
            w_f_gnt = 1'b1;
          end
        end
        default: begin
          w_f_gnt = 1'b0;
          w_l_gnt = 1'b0;
        end
      endcase
    end
  end

  assign f_gnt = w_f_gnt;
  assign l_gnt = w_l_gnt;

  // Memory port mux driven from the winner; idle leaves address and data at zero.
  always_comb begin
    mem_wr_enb  = 1'b0;
    mem_rd_enb  = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    if (w_f_gnt) begin
      mem_rd_enb = 1'b1;
      mem_addr   = f_addr;
    end else if (w_l_gnt) begin
      mem_wr_enb  = l_we;
      mem_rd_enb  = ~l_we;
      mem_addr    = l_addr;
      mem_data_in = l_wdata;
    end else begin
      mem_wr_enb = 1'b0;
      mem_rd_enb = 1'b0;
    end
  end

  // Starvation counter: counts denied loader cycles, saturates, clears on loader grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_l_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (l_req && (r_starve_cnt < STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Owner of the read issued this cycle; loader writes return nothing.
  always_comb begin
    w_rd_owner_nxt = OWN_NONE;
    if (w_f_gnt) begin
      w_rd_owner_nxt = OWN_FETCH;
    end else if (w_l_gnt && !l_we) begin
      w_rd_owner_nxt = OWN_LOADER;
    end else begin
      w_rd_owner_nxt = OWN_NONE;
    end
  end

  // Tag register aligned with the memory's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= OWN_NONE;
    end else begin
      r_rd_owner <= w_rd_owner_nxt;
    end
  end

  assign f_rvalid = (r_rd_owner == OWN_FETCH);
  assign l_rvalid = (r_rd_owner == OWN_LOADER);
  assign f_rdata  = mem_data_out;
  assign l_rdata  = mem_data_out;

endmodule

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Two-port arbiter that shares the single-port 22-bit program memory between the instruction-fetch unit and the program loader/debug port. Every cycle it grants at most one requester. It drives the memory's write-enable, read-enable, address and data-in from the winner and tags the one-cycle-latency read data back to the correct requester. Fetch has priority. A starvation counter guarantees loader progress while the CPU runs.

## Interface
Parameters:
- RAM_WIDTH, 22, instruction word width
- ADDR_SIZE, 11, address width
- STARVE_MAX, 4, consecutive denied loader cycles before the loader is forced to win (range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_SIZE  fetch address
- f_gnt  out  1  fetch granted this cycle
- f_rdata  out  RAM_WIDTH  fetch read data, qualified by f_rvalid
- f_rvalid  out  1  f_rdata valid (cycle after fetch grant)
- l_req  in  1  loader request
- l_we  in  1  loader access is a write (1) or read (0)
- l_addr  in  ADDR_SIZE  loader address
- l_wdata  in  RAM_WIDTH  loader write data
- l_gnt  out  1  loader granted this cycle
- l_rdata  out  RAM_WIDTH  loader read data, qualified by l_rvalid
- l_rvalid  out  1  l_rdata valid (cycle after loader read grant)
- mem_wr_enb  out  1  to memory wr_enb
- mem_rd_enb  out  1  to memory rd_enb
- mem_addr  out  ADDR_SIZE  to memory addr
- mem_data_in  out  RAM_WIDTH  to memory data_in
- mem_data_out  in  RAM_WIDTH  from memory data_out (registered in memory)

## Operation
- Grant is combinational from the requests and registered state. A requester holds req, address and data stable until it sees gnt high at a clock edge.
- Arbitration per cycle:
  - only f_req → fetch wins
  - only l_req → loader wins
  - both, with starve_cnt < STARVE_MAX → fetch wins
  - both, with starve_cnt == STARVE_MAX → loader wins
  - neither → idle
- starve_cnt (4 bits):
  - +1 on each edge where l_req=1 and l_gnt=0, saturating at STARVE_MAX
  - cleared on any edge with l_gnt=1
  - holds when l_req=0
- Memory drive:
  - fetch grant: mem_rd_enb=1, mem_wr_enb=0, mem_addr=f_addr
  - loader grant: mem_addr=l_addr, mem_wr_enb=l_we, mem_rd_enb=~l_we, mem_data_in=l_wdata
  - idle: both enables 0; mem_addr and mem_data_in=0
- Return tagging:
  - register rd_owner ∈ {NONE, FETCH, LOADER}, updated every edge from the current read grant
  - f_rvalid = (rd_owner==FETCH); l_rvalid = (rd_owner==LOADER)
  - f_rdata and l_rdata both equal mem_data_out
- Loader writes never produce an rvalid.
- There is no write-read bypass. Memory ordering alone makes a read granted the cycle after a write return the new data.

## Timing
- Reset (rst_n low, asynchronous):
  - f_gnt, l_gnt, mem_wr_enb, mem_rd_enb forced 0
  - f_rvalid, l_rvalid = 0; rd_owner=NONE; starve_cnt=0
  - mem_addr and mem_data_in = 0
- After deassertion, requests are serviced from the first rising edge.
- Read latency: grant in cycle N → rvalid and data in cycle N+1. Back-to-back grants give one result per cycle.
- Fetch throughput: 1 per cycle until starvation. With both requesting continuously the pattern is STARVE_MAX fetch grants, then 1 loader grant, repeating.
- Reset mid-transaction: an in-flight read's rvalid is dropped. Requesters reissue after reset.
- A request dropped before grant is legal and leaves no side effect other than starve_cnt holding.

## Test plan
- Reset: hold rst_n=0 with f_req=l_req=1 → both gnt=0, both enables=0, both rvalid=0. Release → f_gnt=1 on the first cycle.
- Fetch only: loader writes mem[3]=22'h2A5A5, then f_req with f_addr=3 → f_gnt same cycle, mem_rd_enb=1, next cycle f_rvalid=1 with f_rdata=22'h2A5A5 and l_rvalid=0.
- Loader write then fetch, back-to-back: l_we=1, l_addr=6, l_wdata=22'h0C000 granted in cycle N; fetch addr 6 in N+1 → f_rdata=22'h0C000 in N+2.
- Contention with STARVE_MAX=4 and both requests held high for 10 cycles → grant sequence F,F,F,F,L,F,F,F,F,L; starve_cnt reads 0 after each L.
- Loader read under contention: l_we=0, l_addr=200 with mem[200]=22'h08000 → l_rvalid=1 only in the cycle after l_gnt, l_rdata=22'h08000, f_rvalid=0 that cycle.
- Asynchronous reset asserted mid-cycle right after a fetch grant → f_rvalid stays 0 next cycle and starve_cnt=0.
